// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out shifter. A WIDTH-bit word is taken over a
//   valid/ready handshake and sent out one bit at a time, MSB-first or
//   LSB-first. Each bit is held for CLKS_PER_BIT clocks. The block flags the
//   first cycle of each bit and pulses done for one cycle when a frame ends.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   clr        : synchronous abort / clear, active-high, highest priority
//   D          : parallel word to transmit
//   in_valid   : D is valid this cycle
//   in_ready   : block can accept a word this cycle
//   out        : serial data (IDLE_LEVEL between frames)
//   bit_strobe : high in the first cycle of each bit
//   busy       : frame in progress
//   done       : one-cycle pulse after a frame completes normally
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int   WIDTH        = 8,
  parameter int   CLKS_PER_BIT = 1,
  parameter int   LSB_FIRST    = 0,
  parameter logic IDLE_LEVEL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] D,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
);

  localparam int BCW = $clog2(WIDTH);
  localparam int DCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_next;
  logic [BCW-1:0]   r_bit_cnt;
  logic [BCW-1:0]   w_bit_cnt_next;
  logic [DCW-1:0]   r_div_cnt;
  logic [DCW-1:0]   w_div_cnt_next;
  logic             r_done;
  logic             w_done_next;

  logic             w_div_wrap;
  logic             w_last_bit;
  logic [WIDTH-1:0] w_shifted;
  logic             w_head_bit;

  // Terminal counts compared against the full parameter values.
  assign w_div_wrap = (r_div_cnt == DCW'(CLKS_PER_BIT - 1));
  assign w_last_bit = (r_bit_cnt == BCW'(WIDTH - 1));

  // Direction is fixed at elaboration: the bit on out is always the one the
  // next shift discards, and zeros fill in from the far end.
  generate
    if (LSB_FIRST != 0) begin : g_lsb
      assign w_shifted  = {1'b0, r_shreg[WIDTH-1:1]};
      assign w_head_bit = r_shreg[0];
    end else begin : g_msb
      assign w_shifted  = {r_shreg[WIDTH-2:0], 1'b0};
      assign w_head_bit = r_shreg[WIDTH-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shreg   <= w_shreg_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_div_cnt <= w_div_cnt_next;
      r_done    <= w_done_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shreg_next   = r_shreg;
    w_bit_cnt_next = r_bit_cnt;
    w_div_cnt_next = r_div_cnt;
    w_done_next    = 1'b0;
    in_ready       = 1'b0;
    out            = IDLE_LEVEL;
    bit_strobe     = 1'b0;
    busy           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        in_ready = ~clr;
        if (in_valid && !clr) begin
          w_state_next   = ST_SHIFT;
          w_shreg_next   = D;
          w_bit_cnt_next = '0;
          w_div_cnt_next = '0;
        end
      end
      ST_SHIFT: begin
        busy       = 1'b1;
        out        = w_head_bit;
        bit_strobe = (r_div_cnt == '0);
        if (w_div_wrap) begin
          w_div_cnt_next = '0;
          w_shreg_next   = w_shifted;
          w_bit_cnt_next = r_bit_cnt + BCW'(1);
          if (w_last_bit) begin
            w_state_next   = ST_IDLE;
            w_bit_cnt_next = '0;
            w_done_next    = 1'b1;
          end
        end else begin
          w_div_cnt_next = r_div_cnt + DCW'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Abort wins over everything except the asynchronous reset.
    if (clr) begin
      w_state_next   = ST_IDLE;
      w_shreg_next   = '0;
      w_bit_cnt_next = '0;
      w_div_cnt_next = '0;
      w_done_next    = 1'b0;
    end
  end

  assign done = r_done;

endmodule
